mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single-port data memory between the CPU load/store path (port 0) and the UART program/data loader (port 1). Grants at most one access per cycle, forwards it to the memory port combinationally, and routes the one-cycle-latency read data back to the port that issued it. Alternates fairly by default; port 1 may lock the memory for bursts, bounded so the CPU is never starved. Drives a stall to the CPU program-counter logic while port 0 waits.

## Interface

Parameters:
- AW, 32, address width (word addresses)
- DW, 32, data width
- MAX_BURST, 8, max consecutive locked port-1 grants while port 0 waits (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- r0_req  in  1  port 0 (CPU) access request
- r0_we  in  1  port 0 write enable (1 = write, 0 = read)
- r0_addr  in  AW  port 0 address
- r0_wdata  in  DW  port 0 write data
- r0_gnt  out  1  port 0 access accepted this cycle
- r0_rvalid  out  1  port 0 read data valid
- r0_rdata  out  DW  port 0 read data
- r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata: same as port 0, for port 1 (loader)
- r1_lock  in  1  port 1 requests exclusive access (burst)
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid the cycle after a read strobe
- cpu_stall  out  1  r0_req & ~r0_gnt

## Operation

- State: prio (1 bit, port favoured on contention), burst_cnt (clog2(MAX_BURST+1) bits), rd_pend (1 bit), rd_owner (1 bit).
- Grant decision (combinational, same cycle as req):
  - Neither req: no grant, mem_en=0.
  - One req: grant it.
  - Both req, r1_lock=1, burst_cnt<MAX_BURST: grant port 1.
  - Both req, r1_lock=1, burst_cnt==MAX_BURST: grant port 0.
  - Both req, r1_lock=0: grant port prio.
- gnt is one-hot or zero; r*_req is held with stable fields until gnt (requester obligation).
- Memory port: mem_en = any gnt; mem_we/addr/wdata muxed from granted port; all zero when idle.
- prio update: after a port-0 grant → 1; after a port-1 grant → 0; otherwise unchanged.
- burst_cnt: +1 on a port-1 grant with r0_req=1 (saturates at MAX_BURST); cleared on a port-0 grant or any cycle r0_req=0.
- Read return: on a granted read, rd_pend←1, rd_owner←port; next cycle r{owner}_rvalid=1, r{owner}_rdata=mem_rdata; other port's rvalid=0, rdata=0. Writes produce no rvalid.
- Back-to-back reads from either/both ports are fully pipelined: one grant and one return per cycle.

## Timing

- Reset values: prio=0, burst_cnt=0, rd_pend=0, rd_owner=0; so r*_rvalid=0, r*_rdata=0. gnt/mem_*/cpu_stall are combinational and zero whenever no req.
- Grant latency 0 cycles; read latency 1 cycle after grant; write completes at the grant edge.
- Reset asserted mid-read: pending rvalid is dropped (not delivered) in the cycle after reset; during reset cycles gnt is still driven combinationally but state does not advance.
- r1_lock with r1_req=0: no effect; port 0 granted freely.
- r1_lock deasserted mid-burst: next contention uses prio (which is 0 after a port-1 grant → port 0 wins).
- MAX_BURST=1: locked port 1 and port 0 alternate strictly under contention.

## Test plan

- Reset, then r0 read addr 0x10 with memory model returning 0xDEADBEEF: r0_gnt same cycle, mem_en=1 mem_we=0 mem_addr=0x10; next cycle r0_rvalid=1 r0_rdata=0xDEADBEEF, r1_rvalid=0.
- Both ports request reads continuously, no lock: grants alternate 0,1,0,1…; rvalid follows to matching port one cycle later; cpu_stall high on cycles 2,4,….
- r1_lock=1, both requesting writes continuously, MAX_BURST=8: eight port-1 grants, then one port-0 grant, then eight port-1 grants; cpu_stall high exactly 8 of every 9 cycles.
- r1 write 0x5 to 0x20 then r0 read 0x20 next cycle: r0_rdata=0x5; r1_rvalid never asserts.
- Port 0 read granted, reset asserted next cycle: r0_rvalid stays 0; after reset release with both requesting, port 0 granted first (prio=0).
- Only r1_req with r1_lock=1 for 20 cycles: 20 grants, burst_cnt stays 0, cpu_stall=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port data memory between the CPU load/store
// path (port 0) and the UART loader (port 1). One grant per cycle, forwarded
// combinationally to the memory. Read data comes back one cycle later and is
// routed to the port that issued the read.
//
// Handshake: a requester raises rN_req and holds we/addr/wdata stable until it
// sees rN_gnt high in the same cycle; that cycle is the access. Read data is
// returned with rN_rvalid exactly one cycle after the granted read; there is no
// ready/backpressure on the return path.
module mem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,
    input  logic          r1_req,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    input  logic          r1_lock,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          cpu_stall
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    logic          prio_q, prio_d;           // port favoured on unlocked contention
    logic [BW-1:0] burst_cnt_q, burst_cnt_d; // locked port-1 grants while port 0 waits
    logic          rd_pend_q, rd_pend_d;     // a read was granted last cycle
    logic          rd_owner_q, rd_owner_d;   // which port issued that read

    logic gnt0, gnt1;

    // Grant decision: lone requester wins; contention resolved by bounded lock, else prio.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (r0_req && r1_req) begin
            if (r1_lock) begin
                if (burst_cnt_q < BURST_MAX) gnt1 = 1'b1;
                else                         gnt0 = 1'b1;
            end else if (prio_q) begin
                gnt1 = 1'b1;
            end else begin
                gnt0 = 1'b1;
            end
        end else begin
            gnt0 = r0_req;
            gnt1 = r1_req;
        end
    end

    // Memory port mux: forward the granted port's fields, all zero when idle.
    always_comb begin
        mem_en    = gnt0 | gnt1;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_we    = r0_we;
            mem_addr  = r0_addr;
            mem_wdata = r0_wdata;
        end else if (gnt1) begin
            mem_we    = r1_we;
            mem_addr  = r1_addr;
            mem_wdata = r1_wdata;
        end
    end

    // Next-state: fairness toggle, burst counter, and read-return tracking.
    always_comb begin
        prio_d      = prio_q;
        burst_cnt_d = burst_cnt_q;
        rd_pend_d   = 1'b0;
        rd_owner_d  = rd_owner_q;
        if (gnt0)      prio_d = 1'b1;
        else if (gnt1) prio_d = 1'b0;
        // The counter only measures how long port 0 has been kept waiting.
        if (gnt0 || !r0_req) begin
            burst_cnt_d = '0;
        end else if (gnt1 && burst_cnt_q != BURST_MAX) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
        end
        if (mem_en && !mem_we) begin
            rd_pend_d  = 1'b1;
            rd_owner_d = gnt1;
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q      <= 1'b0;
            burst_cnt_q <= '0;
            rd_pend_q   <= 1'b0;
            rd_owner_q  <= 1'b0;
        end else begin
            prio_q      <= prio_d;
            burst_cnt_q <= burst_cnt_d;
            rd_pend_q   <= rd_pend_d;
            rd_owner_q  <= rd_owner_d;
        end
    end

    // Read return: a return pending while reset is high is dropped, not delivered.
    always_comb begin
        r0_gnt    = gnt0;
        r1_gnt    = gnt1;
        r0_rvalid = rd_pend_q & ~rd_owner_q & ~reset;
        r1_rvalid = rd_pend_q &  rd_owner_q & ~reset;
        r0_rdata  = r0_rvalid ? mem_rdata : '0;
        r1_rdata  = r1_rvalid ? mem_rdata : '0;
        cpu_stall = r0_req & ~gnt0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized phase, checked every
// cycle against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MAX_BURST = 8;
    localparam int EW = DW + 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          r0_req = 1'b0, r0_we = 1'b0;
    logic [AW-1:0] r0_addr = '0;
    logic [DW-1:0] r0_wdata = '0;
    logic          r0_gnt, r0_rvalid;
    logic [DW-1:0] r0_rdata;
    logic          r1_req = 1'b0, r1_we = 1'b0, r1_lock = 1'b0;
    logic [AW-1:0] r1_addr = '0;
    logic [DW-1:0] r1_wdata = '0;
    logic          r1_gnt, r1_rvalid;
    logic [DW-1:0] r1_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          cpu_stall;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_lock(r1_lock),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cpu_stall(cpu_stall)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- memory (environment) ----------------
    logic [DW-1:0] mem [64];
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr[5:0]] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[5:0]];
        else                   mem_rdata <= $urandom;
    end

    // ---------------- reference model ----------------
    logic [DW-1:0] sh_mem [64];
    bit            m_fav1 = 1'b0;  // port 1 favoured on next unlocked contention
    int            m_run = 0;      // consecutive port-1 grants while port 0 waited
    logic [EW-1:0] exp_q[$];       // {valid, owner, data}, one entry per cycle

    function automatic logic [1:0] model_gnt();
        if (r0_req && !r1_req) return 2'b01;
        if (r1_req && !r0_req) return 2'b10;
        if (!r0_req) return 2'b00;
        if (r1_lock) return (m_run < MAX_BURST) ? 2'b10 : 2'b01;
        return m_fav1 ? 2'b10 : 2'b01;
    endfunction

    always @(posedge clk) begin
        logic [1:0]    g;
        logic          we;
        logic [5:0]    a;
        logic [DW-1:0] wd;
        g  = model_gnt();
        we = g[1] ? r1_we : r0_we;
        a  = g[1] ? r1_addr[5:0] : r0_addr[5:0];
        wd = g[1] ? r1_wdata : r0_wdata;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (reset) begin
            exp_q.delete();
            m_fav1 = 1'b0;
            m_run  = 0;
        end else begin
            exp_q.push_back({(g != 2'b00) && !we, g[1], sh_mem[a]});
            if (g == 2'b01) begin
                m_fav1 = 1'b1;
                m_run  = 0;
            end else if (g == 2'b10) begin
                m_fav1 = 1'b0;
                m_run  = r0_req ? ((m_run < MAX_BURST) ? m_run + 1 : MAX_BURST) : 0;
            end else begin
                m_run = 0;
            end
        end
        if (g != 2'b00 && we) sh_mem[a] = wd;
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [1:0]    g;
            logic [EW-1:0] e;
            logic          v0, v1;
            g  = model_gnt();
            e  = (exp_q.size() > 0) ? exp_q[0] : '0;
            v0 = e[EW-1] && !e[EW-2] && !reset;
            v1 = e[EW-1] &&  e[EW-2] && !reset;
            chk("r0_gnt", r0_gnt, g[0]);
            chk("r1_gnt", r1_gnt, g[1]);
            chk("mem_en", mem_en, g != 2'b00);
            chk("mem_we", mem_we, g[0] ? r0_we : (g[1] ? r1_we : 1'b0));
            chk("mem_addr", mem_addr, g[0] ? r0_addr : (g[1] ? r1_addr : '0));
            chk("mem_wdata", mem_wdata, g[0] ? r0_wdata : (g[1] ? r1_wdata : '0));
            chk("cpu_stall", cpu_stall, r0_req && !g[0]);
            chk("r0_rvalid", r0_rvalid, v0);
            chk("r1_rvalid", r1_rvalid, v1);
            chk("r0_rdata", r0_rdata, v0 ? e[DW-1:0] : '0);
            chk("r1_rdata", r1_rdata, v1 ? e[DW-1:0] : '0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        r0_req = req; r0_we = we; r0_addr = a; r0_wdata = d;
    endtask

    task automatic set1(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        r1_req = req; r1_we = we; r1_addr = a; r1_wdata = d;
    endtask

    task automatic idle();
        set0(1'b0, 1'b0, '0, '0);
        set1(1'b0, 1'b0, '0, '0);
        r1_lock = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  stalls;
        logic g0, g1;
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            sh_mem[i] = mem[i];
        end
        mem[16] = 32'hDEADBEEF;
        sh_mem[16] = 32'hDEADBEEF;

        // reset
        step();
        chk_en = 1'b1;
        step();
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_r0_rvalid", r0_rvalid, 1'b0);
        chk("rst_r1_rvalid", r1_rvalid, 1'b0);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_stall", cpu_stall, 1'b0);

        // single port-0 read of 0x10
        step();
        set0(1'b1, 1'b0, 32'h10, '0);
        @(negedge clk);
        chk("t1_r0_gnt", r0_gnt, 1'b1);
        chk("t1_mem_en", mem_en, 1'b1);
        chk("t1_mem_we", mem_we, 1'b0);
        chk("t1_mem_addr", mem_addr, 32'h10);
        step();
        idle();
        @(negedge clk);
        chk("t1_r0_rvalid", r0_rvalid, 1'b1);
        chk("t1_r0_rdata", r0_rdata, 32'hDEADBEEF);
        chk("t1_r1_rvalid", r1_rvalid, 1'b0);

        // unlocked contention alternates starting with port 0
        do_reset();
        set0(1'b1, 1'b0, 32'h1, '0);
        set1(1'b1, 1'b0, 32'h2, '0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("alt_r0_gnt", r0_gnt, (i % 2) == 0);
            chk("alt_r1_gnt", r1_gnt, (i % 2) == 1);
            chk("alt_stall", cpu_stall, (i % 2) == 1);
            if (i > 0) chk("alt_r0_rvalid", r0_rvalid, (i % 2) == 1);
            step();
        end

        // locked burst: 8 port-1 grants then one port-0 grant
        idle();
        step();
        r1_lock = 1'b1;
        set0(1'b1, 1'b1, 32'h30, 32'hA0);
        set1(1'b1, 1'b1, 32'h31, 32'hB1);
        stalls = 0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            chk("burst_r1_gnt", r1_gnt, (i % 9) < 8);
            if (cpu_stall) stalls++;
            step();
        end
        chk("burst_stall_count", stalls, 16);

        // write via port 1, read back via port 0
        idle();
        set1(1'b1, 1'b1, 32'h20, 32'h5);
        @(negedge clk);
        chk("wr_r1_gnt", r1_gnt, 1'b1);
        step();
        idle();
        set0(1'b1, 1'b0, 32'h20, '0);
        @(negedge clk);
        chk("rd_r0_gnt", r0_gnt, 1'b1);
        chk("wr_r1_rvalid", r1_rvalid, 1'b0);
        step();
        idle();
        @(negedge clk);
        chk("rd_r0_rvalid", r0_rvalid, 1'b1);
        chk("rd_r0_rdata", r0_rdata, 32'h5);
        chk("rd_r1_rvalid", r1_rvalid, 1'b0);

        // reset right after a granted read drops the return
        set0(1'b1, 1'b0, 32'h10, '0);
        @(negedge clk);
        chk("rr_r0_gnt", r0_gnt, 1'b1);
        step();
        idle();
        reset = 1'b1;
        @(negedge clk);
        chk("rr_r0_rvalid", r0_rvalid, 1'b0);
        step();
        reset = 1'b0;
        set0(1'b1, 1'b0, 32'h3, '0);
        set1(1'b1, 1'b0, 32'h4, '0);
        @(negedge clk);
        chk("rr_r0_first", r0_gnt, 1'b1);
        chk("rr_r1_wait", r1_gnt, 1'b0);
        chk("rr_r0_rvalid2", r0_rvalid, 1'b0);
        step();
        idle();
        step();

        // port 1 alone with lock: granted every cycle, no stall
        r1_lock = 1'b1;
        set1(1'b1, 1'b0, 32'h8, '0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("solo_r1_gnt", r1_gnt, 1'b1);
            chk("solo_stall", cpu_stall, 1'b0);
            step();
        end
        idle();
        step();

        // randomized traffic with requester hold obligation
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            g0 = r0_gnt;
            g1 = r1_gnt;
            step();
            reset = ($urandom_range(0, 199) == 0);
            if (!r0_req || g0)
                set0($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                     AW'($urandom_range(0, 63)), $urandom);
            if (!r1_req || g1)
                set1($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                     AW'($urandom_range(0, 63)), $urandom);
            if ($urandom_range(0, 15) == 0) r1_lock = ~r1_lock;
        end
        idle();
        reset = 1'b0;
        step();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
